// File: rtl/rx_pkg.sv
// Shared widths, saturation limits and sample type for the RX requantizer path.
package rx_pkg;
  localparam int RX_FILT_W   = 232;
  localparam int RX_SAMPLE_W = 16;
  localparam int RX_SAT_MAX  = 32767;
  localparam int RX_SAT_MIN  = -32768;

  typedef logic signed [RX_SAMPLE_W-1:0] rx_sample_t;
endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO succeeds only alongside a pop.
module rx_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             cnt_q;
  logic                    do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rx_requantizer.sv
// Decimates FIR accumulator samples, rounds/shifts/saturates to 16 bits and queues them for the detector.
module rx_requantizer
  import rx_pkg::*;
#(
  parameter int IN_W       = RX_FILT_W,
  parameter int OUT_W      = RX_SAMPLE_W,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(FIFO_DEPTH)
) (
  input  logic                    crx_clk,
  input  logic                    rrx_rst_n,
  input  logic                    erx_en,
  input  logic signed [IN_W-1:0]  isample,
  input  logic                    isample_trig,
  input  logic [7:0]              ishift,
  input  logic [3:0]              idecim,
  input  logic                    iready,
  input  logic                    iclear_flags,
  output logic signed [OUT_W-1:0] osample,
  output logic                    ovalid,
  output logic [CW:0]             ofifo_count,
  output logic                    osat,
  output logic                    ooverflow
);
  localparam int SMAX = (IN_W - 1 > 255) ? 255 : IN_W - 1;

  logic [3:0]             phase_q, phase_d, d_eff;
  logic                   accept;
  logic [7:0]             s_clamp, s_q;
  logic signed [IN_W-1:0] x_q;
  logic                   v_q;
  logic signed [IN_W:0]   xe, rnd, sum, r;
  logic                   hi, lo;
  rx_sample_t             res_d, res_q;
  logic                   rv_q;
  logic [OUT_W-1:0]       head, last_q;
  logic                   full, empty, pop;
  logic                   osat_q, ovf_q, sat_ev, ovf_ev;

  // Phase counts every trigger; a phase left beyond a shrunken D wraps without accepting.
  assign d_eff   = (idecim == 4'd0) ? 4'd1 : idecim;
  assign accept  = isample_trig && (phase_q == 4'd0);
  assign s_clamp = (ishift > 8'(SMAX)) ? 8'(SMAX) : ishift;

  always_comb begin
    phase_d = phase_q;
    if (isample_trig) phase_d = (phase_q >= d_eff - 4'd1) ? 4'd0 : phase_q + 4'd1;
  end

  // One extra bit of headroom so the rounding bias can never wrap the sum.
  always_comb begin
    xe    = {x_q[IN_W-1], x_q};
    rnd   = (s_q == 8'd0) ? '0 : ((IN_W+1)'(1) << (s_q - 8'd1));
    sum   = xe + rnd;
    r     = sum >>> s_q;
    hi    = (r > RX_SAT_MAX);
    lo    = (r < RX_SAT_MIN);
    res_d = hi ? rx_sample_t'(RX_SAT_MAX) : lo ? rx_sample_t'(RX_SAT_MIN) : r[RX_SAMPLE_W-1:0];
  end

  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      phase_q <= '0;
      x_q     <= '0;
      s_q     <= '0;
      v_q     <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
    end else if (!erx_en) begin
      phase_q <= '0;
      v_q     <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      v_q     <= accept;
      if (accept) begin
        x_q <= isample;
        s_q <= s_clamp;
      end
      rv_q <= v_q;
      if (v_q) res_q <= res_d;
    end
  end

  rx_sync_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (crx_clk),
    .rst_n_i (rrx_rst_n),
    .flush_i (!erx_en),
    .push_i  (rv_q),
    .pop_i   (pop),
    .din_i   (OUT_W'(res_q)),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (ofifo_count)
  );

  assign ovalid = !empty;
  assign pop    = ovalid && iready;
  assign sat_ev = erx_en && v_q && (hi || lo);
  assign ovf_ev = erx_en && rv_q && full && !pop;

  always_ff @(posedge crx_clk) begin
    if (!rrx_rst_n) begin
      osat_q <= 1'b0;
      ovf_q  <= 1'b0;
      last_q <= '0;
    end else begin
      osat_q <= (osat_q && !iclear_flags) || sat_ev;
      ovf_q  <= (ovf_q && !iclear_flags) || ovf_ev;
      if (ovalid) last_q <= head;
    end
  end

  assign osample   = ovalid ? head : last_q;
  assign osat      = osat_q;
  assign ooverflow = ovf_q;
endmodule

// File: doc/rx_requantizer.md
Name: rx_requantizer

Overview:
- Downstream consumer of the RX FIR filter stage.
- Takes the wide signed filter accumulator on each filter ready-trigger and decimates by a run-time factor.
- Rescales it by a run-time arithmetic right shift with round-half-up, then saturates to 16-bit signed.
- Buffers results in a 4-entry FIFO presented on a valid/ready interface to the downstream correlator/detector.

Parameters:
- IN_W, 232, width of the signed filter accumulator input.
- OUT_W, 16, width of the signed requantized output sample.
- FIFO_DEPTH, 4, output FIFO entries (power of two, at least 2).

Ports:
- crx_clk  input  1  rx clock; single clock domain.
- rrx_rst_n  input  1  synchronous, active-low reset.
- erx_en  input  1  module enable.
- isample  input  IN_W  signed filtered sample from the FIR stage.
- isample_trig  input  1  one-cycle pulse; isample is valid this cycle.
- ishift  input  8  right-shift amount, sampled with each accepted sample.
- idecim  input  4  decimation factor 1..15; 0 is treated as 1.
- iready  input  1  downstream accepts head of FIFO.
- iclear_flags  input  1  clears the sticky flags.
- osample  output  OUT_W  signed requantized sample at FIFO head.
- ovalid  output  1  FIFO non-empty.
- ofifo_count  output  3  current FIFO occupancy, 0..4.
- osat  output  1  sticky: at least one sample saturated.
- ooverflow  output  1  sticky: at least one sample dropped because the FIFO was full.

Behaviour:
- Reset (rrx_rst_n=0 at a clock edge):
  - All state clears, mid-operation included: phase counter, pipeline register, FIFO pointers and contents, osat, ooverflow.
  - All outputs are 0.
  - Reset has priority over every other input.
- erx_en=0 at an edge: clears phase, pipeline and FIFO (ovalid=0, ofifo_count=0). osat and ooverflow are retained.
- Decimation:
  - The phase counter runs 0..D-1, where D = max(idecim,1).
  - It advances on each isample_trig and wraps to 0 after D-1.
  - A trigger is accepted only when phase==0.
  - If idecim changes while phase >= the new D, the next trigger wraps the phase to 0 and is not accepted.
- Stage 1, on an accepted trigger at edge T:
  - Capture isample and S = min(ishift, IN_W-1).
  - Pipeline valid bit is set.
- Stage 2, at edge T+1:
  - Compute in IN_W+1 bits: r = (x + (S>0 ? 2^(S-1) : 0)) >>> S (arithmetic shift).
  - If r > 32767, output 32767; if r < -32768, output -32768. Either case sets osat.
  - Push the result into the FIFO.
- Latency: with the FIFO empty, a trigger at edge T gives ovalid=1 and osample valid after edge T+2.
- FIFO:
  - A pop occurs at an edge where ovalid=1 and iready=1. iready while ovalid=0 is ignored.
  - Push while full with no pop in the same cycle: the new sample is dropped, ooverflow is set, and contents are unchanged.
  - Push and pop in the same cycle when full: both happen; occupancy stays 4 and no overflow.
  - Push and pop in the same cycle when empty: not possible, since ovalid=0.
  - Order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- osample:
  - Always shows the head entry when ovalid=1.
  - Holds its last value when ovalid=0; after reset it is 0.
- Sticky flags:
  - iclear_flags clears osat and ooverflow at the edge.
  - If a set event occurs in the same cycle as iclear_flags, the flag ends at 1 (set wins).
- Consecutive triggers on back-to-back cycles are supported; throughput is 1 sample per clock.

Decomposition:
- Package rx_pkg holds:
  - RX_FILT_W = 232, RX_SAMPLE_W = 16, RX_SAT_MAX = 32767, RX_SAT_MIN = -32768.
  - The typedef rx_sample_t for the signed 16-bit sample.
- One sub-module, rx_sync_fifo: parameterised width and depth, with push/pop/full/empty/count.
- The decimation, rounding and saturation logic stays in rx_requantizer.

Test Plan:
- Basic scaling: ishift=15, idecim=1, iready=1, trigger isample=32768000 at edge T -> osample=1000 with ovalid=1 after edge T+2 for one cycle; osat=0.
- Rounding: ishift=15, inputs 16384, 16383, -16384, -16385 -> outputs 1, 0, 0, -1.
- Saturation and flag clear: ishift=15, input 2^40 -> osample=32767, osat=1; input -2^40 -> -32768. Pulse iclear_flags together with a new saturating sample -> osat stays 1. Pulse iclear_flags alone -> osat=0.
- Decimation: idecim=3, ishift=15, triggers carrying 1..7 (each <<15) -> outputs 1, 4, 7 only. Then set idecim=0 -> every trigger produces an output.
- FIFO full/overflow: iready=0, ishift=0, 5 triggers with values 10..14 -> ofifo_count=4, ooverflow=1. Drain -> 10, 11, 12, 13. Full with push and pop in the same cycle -> count stays 4, no overflow.
- Reset/enable mid-operation: with 3 entries queued, drive rrx_rst_n=0 for one edge -> ovalid=0, ofifo_count=0, osample=0, flags 0. Repeat with erx_en=0 -> FIFO flushed, a previously set ooverflow is retained.
